// File: rtl/pingpong_bank_scheduler.sv
// Ping-pong scheduler for two external RAM banks: the producer fills one bank
// while the consumer drains the other, and the banks swap once both sides finish.
`timescale 1ns/1ps

module pingpong_bank_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // Handshakes: a word moves on any cycle where valid & ready are both high.
  // The producer must hold wr_valid/wr_data until wr_ready; rd_req is a plain
  // request with no ready, and a refused request is dropped, not queued.
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              wr_bank,
  output logic              swap_pulse,
  output logic              ram0_we,
  output logic              ram1_we,
  output logic [ADDR_W-1:0] ram0_waddr,
  output logic [ADDR_W-1:0] ram1_waddr,
  output logic [DATA_W-1:0] ram0_wdata,
  output logic [DATA_W-1:0] ram1_wdata,
  output logic              ram0_re,
  output logic              ram1_re,
  output logic [ADDR_W-1:0] ram0_raddr,
  output logic [ADDR_W-1:0] ram1_raddr,
  input  logic [DATA_W-1:0] ram0_rdata,
  input  logic [DATA_W-1:0] ram1_rdata,
  output logic [1:0]        dbg_wr_state
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    SWAP = 2'd2
  } wr_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  wr_state_t         wr_state;
  wr_state_t         wr_state_nxt;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [1:0]        full;
  logic              rd_pending;
  logic              rd_bank_q;
  logic              rd_last_q;

  logic              wr_accept;
  logic              wr_last;
  logic              rd_bank;
  logic              rd_issue;
  logic              rd_final;

  assign rd_bank   = ~wr_bank_q;
  assign wr_accept = wr_valid & wr_ready;
  assign wr_last   = wr_accept & (wptr == LAST_ADDR);
  // Reads are held off in SWAP so the bank roles never change under an issue.
  assign rd_issue  = resetn & rd_req & full[rd_bank] & (wr_state != SWAP);
  assign rd_final  = rd_issue & (rptr == LAST_ADDR);

  // Writer FSM: outputs gated by resetn so everything reads 0 while in reset.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_ready     = 1'b0;
    swap_pulse   = 1'b0;
    case (wr_state)
      FILL: begin
        wr_ready = resetn;
        if (wr_last) wr_state_nxt = HOLD;
      end
      HOLD: begin
        if (!full[rd_bank] && !rd_pending) wr_state_nxt = SWAP;
      end
      SWAP: begin
        swap_pulse   = resetn;
        wr_state_nxt = FILL;
      end
      default: wr_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state   <= FILL;
      wr_bank_q  <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      full       <= 2'b00;
      rd_pending <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      wr_state   <= wr_state_nxt;
      rd_pending <= rd_issue;
      rd_last_q  <= rd_final;

      if (wr_accept) begin
        wptr <= wr_last ? '0 : wptr + ADDR_ONE;
      end
      if (wr_last) begin
        full[wr_bank_q] <= 1'b1;
      end

      if (rd_issue) begin
        rptr      <= rd_final ? '0 : rptr + ADDR_ONE;
        rd_bank_q <= rd_bank;
      end
      // The read and write banks always differ, so these two never hit the same bit.
      if (rd_final) begin
        full[rd_bank] <= 1'b0;
      end

      if (wr_state == SWAP) begin
        wr_bank_q <= ~wr_bank_q;
        rptr      <= '0;
      end
    end
  end

  assign wr_bank      = wr_bank_q;
  assign dbg_wr_state = wr_state;

  assign rd_valid = rd_pending;
  assign rd_last  = rd_pending & rd_last_q;
  assign rd_data  = rd_pending ? (rd_bank_q ? ram1_rdata : ram0_rdata) : '0;

  // Idle bank ports are parked at zero.
  assign ram0_we    = wr_accept & ~wr_bank_q;
  assign ram1_we    = wr_accept &  wr_bank_q;
  assign ram0_waddr = ram0_we ? wptr : '0;
  assign ram1_waddr = ram1_we ? wptr : '0;
  assign ram0_wdata = ram0_we ? wr_data : '0;
  assign ram1_wdata = ram1_we ? wr_data : '0;

  assign ram0_re    = rd_issue & ~rd_bank;
  assign ram1_re    = rd_issue &  rd_bank;
  assign ram0_raddr = ram0_re ? rptr : '0;
  assign ram1_raddr = ram1_re ? rptr : '0;

endmodule
